// File: rtl/imem_pkg.sv
// Shared types and the address legality check for the instruction-memory arbiter.
package imem_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  typedef enum logic {
    GNT_F = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int unsigned CHK_ADDR_W = 64;

  // Word-aligned and inside the array; callers zero-extend their address to CHK_ADDR_W.
  function automatic logic addr_ok(input logic [CHK_ADDR_W-1:0] addr,
                                   input int unsigned          mem_size);
    return (addr[1:0] == 2'b00) &&
           (addr[CHK_ADDR_W-1:2] < (CHK_ADDR_W-2)'(mem_size));
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with per-requester enable mask and last-grant memory.
module rr_arb2
  import imem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_f,
  input  logic req_d,
  input  logic en_f,
  input  logic en_d,
  output logic gnt_f_c,
  output logic gnt_d_c
);

  grant_t last_q;
  logic   vld_f;
  logic   vld_d;

  // On conflict, the side that did not win last time gets the slot.
  always_comb begin
    vld_f   = req_f && en_f;
    vld_d   = req_d && en_d;
    gnt_f_c = vld_f && (!vld_d || (last_q == GNT_D));
    gnt_d_c = vld_d && !gnt_f_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_D;
    end else if (gnt_f_c) begin
      last_q <= GNT_F;
    end else if (gnt_d_c) begin
      last_q <= GNT_D;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/debug arbiter for the single-ported instruction memory, with loader halt control.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        f_req_valid,
  output logic                        f_req_ready,
  input  logic [ADDR_WIDTH-1:0]       f_addr,
  output logic                        f_rsp_valid,
  output logic [DATA_WIDTH-1:0]       f_rsp_data,
  output logic                        f_rsp_err,
  input  logic                        d_req_valid,
  output logic                        d_req_ready,
  input  logic                        d_we,
  input  logic [ADDR_WIDTH-1:0]       d_addr,
  input  logic [DATA_WIDTH-1:0]       d_wdata,
  output logic                        d_rsp_valid,
  output logic [DATA_WIDTH-1:0]       d_rsp_data,
  output logic                        d_rsp_err,
  input  logic                        halt_req,
  output logic                        halted,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic                        mem_we,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
);

  localparam int unsigned IDX_W = $clog2(MEM_SIZE);

  halt_state_t state_q;
  halt_state_t state_d;
  logic        f_en;
  logic        gnt_f;
  logic        gnt_d;
  logic        f_ok;
  logic        d_ok;

  // Halt FSM: fetch is masked from the cycle halt_req is seen until the return to RUN.
  always_comb begin
    state_d = state_q;
    f_en    = 1'b0;
    unique case (state_q)
      RUN: begin
        f_en = !halt_req;
        if (halt_req) state_d = DRAIN;
      end
      DRAIN:   state_d = halt_req ? HALTED : RUN;
      HALTED:  if (!halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == HALTED);
    end
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_f   (f_req_valid),
    .req_d   (d_req_valid),
    .en_f    (f_en),
    .en_d    (1'b1),
    .gnt_f_c (gnt_f),
    .gnt_d_c (gnt_d)
  );

  assign f_ok        = addr_ok(CHK_ADDR_W'(f_addr), MEM_SIZE);
  assign d_ok        = addr_ok(CHK_ADDR_W'(d_addr), MEM_SIZE);
  assign f_req_ready = gnt_f;
  assign d_req_ready = gnt_d;

  // Only the granted requester reaches the array; erroring writes are suppressed.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (gnt_f) begin
      mem_addr = f_addr[2 +: IDX_W];
    end else if (gnt_d) begin
      mem_addr  = d_addr[2 +: IDX_W];
      mem_we    = d_we && d_ok;
      mem_wdata = d_wdata;
    end
  end

  // Response register: read data captured in the grant cycle, presented for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rsp_valid <= 1'b0;
      f_rsp_err   <= 1'b0;
      f_rsp_data  <= '0;
      d_rsp_valid <= 1'b0;
      d_rsp_err   <= 1'b0;
      d_rsp_data  <= '0;
    end else begin
      f_rsp_valid <= gnt_f;
      f_rsp_err   <= gnt_f && !f_ok;
      f_rsp_data  <= (gnt_f && f_ok) ? mem_rdata : '0;
      d_rsp_valid <= gnt_d;
      d_rsp_err   <= gnt_d && !d_ok;
      d_rsp_data  <= (gnt_d && d_ok && !d_we) ? mem_rdata : '0;
    end
  end

endmodule
